// File: rtl/cordic_pipe.sv
// Fully pipelined CORDIC (rotation/vectoring per sample) with a global valid/ready stall.
// Define CORDIC_GAIN_COMP_EN to append a 1/K gain-compensation stage (latency STAGES+1).

module cordic_stage #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 14,
  parameter int SHIFT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic             vld,
  input  logic             mode,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] z,
  output logic             vld_r,
  output logic             mode_r,
  output logic [WIDTH-1:0] x_r,
  output logic [WIDTH-1:0] y_r,
  output logic [WIDTH-1:0] z_r
);
  localparam int QB = 60;

  // atan(1/n) in Q60 by Taylor series, integer-only so any tool can fold it
  function automatic longint atan_inv(input longint n);
    longint one, p, acc;
    bit     done;
    one  = longint'(1) << QB;
    p    = n;
    acc  = 0;
    done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (!done) begin
        if (k % 2 == 0) acc = acc + (one / p) / longint'(2 * k + 1);
        else            acc = acc - (one / p) / longint'(2 * k + 1);
        if (p > one / (n * n)) done = 1'b1;
        else                   p = p * n * n;
      end
    end
    return acc;
  endfunction

  // atan(1) = atan(1/2) + atan(1/3) keeps the series fast-converging for stage 0
  function automatic longint angle_const(input int i);
    longint a;
    a = (i == 0) ? atan_inv(2) + atan_inv(3) : atan_inv(longint'(1) << i);
    return (a + (longint'(1) << (QB - 1 - FRAC))) >>> (QB - FRAC);
  endfunction

  localparam logic [WIDTH-1:0] ANGLE = WIDTH'(angle_const(SHIFT));

  logic             sub;
  logic [WIDTH-1:0] xs, ys, x_n, y_n, z_n;

  // sub=1 means d=+1: subtract the shifted y and the angle, add the shifted x
  always_comb begin
    sub = mode ? y[WIDTH-1] : ~z[WIDTH-1];
    xs  = $signed(x) >>> SHIFT;
    ys  = $signed(y) >>> SHIFT;
    x_n = x + (ys ^ {WIDTH{sub}}) + {{(WIDTH-1){1'b0}}, sub};
    y_n = y + (xs ^ {WIDTH{~sub}}) + {{(WIDTH-1){1'b0}}, ~sub};
    z_n = z + (ANGLE ^ {WIDTH{sub}}) + {{(WIDTH-1){1'b0}}, sub};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_r  <= 1'b0;
      mode_r <= 1'b0;
      x_r    <= '0;
      y_r    <= '0;
      z_r    <= '0;
    end else if (adv) begin
      vld_r  <= vld;
      mode_r <= mode;
      x_r    <= x_n;
      y_r    <= y_n;
      z_r    <= z_n;
    end
  end
endmodule

module cordic_pipe #(
  parameter int WIDTH  = 16,
  parameter int FRAC   = 14,
  parameter int STAGES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  input  logic [WIDTH-1:0] z_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] x_out,
  output logic [WIDTH-1:0] y_out,
  output logic [WIDTH-1:0] z_out
);
  logic                       adv;
  logic [STAGES:0]            vld_pipe, mode_pipe;
  logic [STAGES:0][WIDTH-1:0] x_pipe, y_pipe, z_pipe;
  logic                       unused_mode;

  // single global stall: every stage, bubbles included, moves together
  assign adv          = !out_valid || out_ready;
  assign in_ready     = adv;
  assign vld_pipe[0]  = in_valid;
  assign mode_pipe[0] = mode;
  assign x_pipe[0]    = x_in;
  assign y_pipe[0]    = y_in;
  assign z_pipe[0]    = z_in;
  assign unused_mode  = mode_pipe[STAGES];

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    cordic_stage #(.WIDTH(WIDTH), .FRAC(FRAC), .SHIFT(i)) u_stage (
      .clk    (clk),
      .rst    (rst),
      .adv    (adv),
      .vld    (vld_pipe[i]),
      .mode   (mode_pipe[i]),
      .x      (x_pipe[i]),
      .y      (y_pipe[i]),
      .z      (z_pipe[i]),
      .vld_r  (vld_pipe[i+1]),
      .mode_r (mode_pipe[i+1]),
      .x_r    (x_pipe[i+1]),
      .y_r    (y_pipe[i+1]),
      .z_r    (z_pipe[i+1])
    );
  end

`ifdef CORDIC_GAIN_COMP_EN
  // G = round(2^FRAC / K); 1/K^2 accumulated in Q30, then integer sqrt with one guard bit
  function automatic longint gain_const();
    longint      one, r;
    logic [63:0] v, s, b;
    int          sh;
    one = longint'(1) << 30;
    r   = one;
    for (int i = 0; i < STAGES; i++) r = (r << 30) / (one + (one >> (2 * i)));
    sh = 2 * FRAC + 2 - 30;
    v  = (sh >= 0) ? (64'(r) << sh) : (64'(r) >> (-sh));
    s  = '0;
    for (int k = 31; k >= 0; k--) begin
      b = s | (64'd1 << k);
      if (b * b <= v) s = b;
    end
    return longint'((s + 64'd1) >> 1);
  endfunction

  localparam logic signed [WIDTH-1:0]   GAIN = WIDTH'(gain_const());
  localparam logic signed [2*WIDTH-1:0] HALF = ((2*WIDTH)'(1) << FRAC) >> 1;

  logic signed [2*WIDTH-1:0] x_prod, y_prod;
  logic                      vld_c;
  logic [WIDTH-1:0]          x_c, y_c, z_c;

  assign x_prod = (2*WIDTH)'($signed(x_pipe[STAGES])) * (2*WIDTH)'(GAIN) + HALF;
  assign y_prod = (2*WIDTH)'($signed(y_pipe[STAGES])) * (2*WIDTH)'(GAIN) + HALF;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_c <= 1'b0;
      x_c   <= '0;
      y_c   <= '0;
      z_c   <= '0;
    end else if (adv) begin
      vld_c <= vld_pipe[STAGES];
      x_c   <= WIDTH'(x_prod >>> FRAC);
      y_c   <= WIDTH'(y_prod >>> FRAC);
      z_c   <= z_pipe[STAGES];
    end
  end

  assign out_valid = vld_c;
  assign x_out     = x_c;
  assign y_out     = y_c;
  assign z_out     = z_c;
`else
  assign out_valid = vld_pipe[STAGES];
  assign x_out     = x_pipe[STAGES];
  assign y_out     = y_pipe[STAGES];
  assign z_out     = z_pipe[STAGES];
`endif
endmodule

// File: tb/tb_cordic_pipe.sv
// Directed bench for cordic_pipe: hand-computed vectors plus an ideal-trig reference for streams.
`timescale 1ns/1ps
module tb_cordic_pipe;
  localparam int WIDTH  = 16;
  localparam int FRAC   = 14;
  localparam int STAGES = 16;
  localparam int TOL    = 10;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int LAT = STAGES + 1;
  localparam int R0X = 9949, R1X = 7035, VX = 11585, VXT = 4;
`else
  localparam int LAT = STAGES;
  localparam int R0X = 16384, R1X = 11585, VX = 19078, VXT = 8;
`endif

  typedef struct { int x; int y; int z; } res_t;

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, mode = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid;
  logic [WIDTH-1:0] x_in = '0, y_in = '0, z_in = '0;
  logic [WIDTH-1:0] x_out, y_out, z_out;

  res_t exp_q[$];
  res_t mon_e;
  int   n_chk = 0, n_fail = 0, n_rx = 0, rx0, cnt;
  bit   mon_en = 1'b0;
  real  gain;

  cordic_pipe #(.WIDTH(WIDTH), .FRAC(FRAC), .STAGES(STAGES)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .x_in(x_in), .y_in(y_in), .z_in(z_in), .out_valid(out_valid), .out_ready(out_ready),
    .x_out(x_out), .y_out(y_out), .z_out(z_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp, input longint tol = 0);
    n_chk++;
    if (got > exp + tol || got < exp - tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d) at %0t", tag, got, exp, tol, $time);
    end
  endtask

  function automatic int rnd(input real r);
    return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
  endfunction

  // ideal CORDIC result: rotation by z, or magnitude/angle of (x,y), times the net gain
  function automatic res_t model(input bit m, input int x, input int y, input int z);
    res_t r;
    real  a;
    if (!m) begin
      a   = z / 16384.0;
      r.x = rnd(gain * (x * $cos(a) - y * $sin(a)));
      r.y = rnd(gain * (y * $cos(a) + x * $sin(a)));
      r.z = 0;
    end else begin
      r.x = rnd(gain * $sqrt(real'(x) * x + real'(y) * y));
      r.y = 0;
      r.z = z + rnd($atan2(real'(y), real'(x)) * 16384.0);
    end
    return r;
  endfunction

  task automatic drive(input bit m, input int x, input int y, input int z);
    int w;
    w = 0;
    mode = m; x_in = WIDTH'(x); y_in = WIDTH'(y); z_in = WIDTH'(z); in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && w < 200) begin @(negedge clk); w++; end
    if (!in_ready) chk("drive_timeout", 0, 1);
    else exp_q.push_back(model(m, x, y, z));
    @(posedge clk); #1;
  endtask

  task automatic single(input string tag, input bit m, input int x, input int y, input int z,
                        input int ex, input int ey, input int ez, input int txy, input int tz);
    int cyc;
    cyc = 0;
    @(posedge clk); #1;
    mode = m; x_in = WIDTH'(x); y_in = WIDTH'(y); z_in = WIDTH'(z); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    do begin @(negedge clk); cyc++; end while (!out_valid && cyc < LAT + 8);
    chk({tag, "_lat"}, out_valid ? cyc : -1, LAT);
    chk({tag, "_x"}, $signed(x_out), ex, txy);
    chk({tag, "_y"}, $signed(y_out), ey, txy);
    chk({tag, "_z"}, $signed(z_out), ez, tz);
    @(negedge clk);
    chk({tag, "_pulse"}, out_valid, 0);
  endtask

  task automatic drain(input string tag);
    int w;
    w = 0;
    while ((exp_q.size() != 0 || out_valid) && w < 300) begin @(negedge clk); w++; end
    chk({tag, "_left"}, exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (mon_en && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
      else begin
        mon_e = exp_q.pop_front();
        chk("stream_x", $signed(x_out), mon_e.x, TOL);
        chk("stream_y", $signed(y_out), mon_e.y, TOL);
        chk("stream_z", $signed(z_out), mon_e.z, TOL);
        n_rx++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    gain = 1.0;
    for (int i = 0; i < STAGES; i++) gain = gain * $sqrt(1.0 + $pow(2.0, -2.0 * i));
`ifdef CORDIC_GAIN_COMP_EN
    gain = gain * 9949.0 / 16384.0;
`endif
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_x", x_out, 0);
    chk("rst_y", y_out, 0);
    chk("rst_z", z_out, 0);
    @(negedge clk);
    rst = 1'b0;

    single("rot_z0", 0, 9949, 0, 0, R0X, 0, 0, 4, 4);
    single("rot_pi4", 0, 9949, 0, 12868, R1X, R1X, 0, 4, 4);
    single("vec_45", 1, 8192, 8192, 0, VX, 0, 12868, VXT, 4);

    // backpressure: stall two cycles after the first result so the input side also blocks
    mon_en = 1'b1;
    rx0 = n_rx;
    @(posedge clk); #1;
    fork
      begin
        for (int k = 0; k < 20; k++) drive(0, 2000 + 500 * k, 300, (k - 10) * 700);
        in_valid = 1'b0;
      end
      begin
        int w;
        w = 0;
        while (!out_valid && w < 100) begin @(negedge clk); w++; end
        chk("bp_first_out", out_valid, 1);
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
          chk("bp_in_ready", in_ready, 0);
          chk("bp_valid", out_valid, 1);
          if (exp_q.size() > 0) begin
            chk("bp_hold_x", $signed(x_out), exp_q[0].x, TOL);
            chk("bp_hold_z", $signed(z_out), exp_q[0].z, TOL);
          end else chk("bp_hold_queue", 0, 1);
          @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain("bp");
    chk("bp_count", n_rx - rx0, 20);

    // alternating modes, back-to-back
    rx0 = n_rx;
    @(posedge clk); #1;
    fork
      begin
        for (int k = 0; k < 12; k++) begin
          if (k % 2 == 0) drive(0, 6000 + 200 * k, 1000, k * 1500 - 8000);
          else            drive(1, 5000 + 150 * k, (k - 6) * 700, 500 * k);
        end
        in_valid = 1'b0;
      end
      begin
        int w, run;
        w = 0;
        run = 0;
        while (!out_valid && w < 100) begin @(negedge clk); w++; end
        while (out_valid && run < 40) begin run++; @(negedge clk); end
        chk("mix_contig", run, 12);
      end
    join
    drain("mix");
    chk("mix_count", n_rx - rx0, 12);

    // reset with the pipeline full and results already on the output
    mon_en = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 18; k++) begin
      mode = 1'b0; x_in = WIDTH'(3000 + 100 * k); y_in = '0; z_in = WIDTH'(1000); in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_pre_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_x", x_out, 0);
    chk("rst_mid_y", y_out, 0);
    chk("rst_mid_z", z_out, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (LAT + 4) begin @(negedge clk); if (out_valid) cnt++; end
    chk("rst_stale", cnt, 0);
    single("post_rst", 0, 9949, 0, 0, R0X, 0, 0, 4, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
